// File: rtl/fir_seq_ctrl.sv
// Control sequencer for the 11-tap FIR: clears the data RAM, accepts samples,
// walks the tap/data RAMs for each MAC pass and emits one output beat per sample.
// Optional FIR_SEQ_TLAST_CHK_EN adds a sticky tlast-mismatch flag on err_tlast.
module fir_seq_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   ap_start,
  input  logic [pDATA_WIDTH-1:0] data_len,
  input  logic                   ss_tvalid,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic                   sm_tlast,
  output logic [3:0]             data_WE,
  output logic                   data_EN,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic                   data_sel_zero,
  output logic                   tap_EN,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic                   mac_clr,
  output logic                   mac_en,
  output logic                   ap_idle,
  output logic                   ap_done,
  output logic                   err_tlast,
  output logic [2:0]             dbg_state
);

  localparam int CW = $clog2(Tape_Num + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(Tape_Num - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLR     = 3'd1,
    S_WAIT_IN = 3'd2,
    S_MAC     = 3'd3,
    S_DRAIN   = 3'd4,
    S_OUT     = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          k;
  logic [CW-1:0]          wr_ptr;
  logic [pDATA_WIDTH-1:0] count;
  logic [pDATA_WIDTH-1:0] len;
  logic [CW:0]            mac_idx;
  logic                   accept;
  logic                   last_beat;
  logic                   final_beat;

  function automatic logic [pADDR_WIDTH-1:0] to_byte(input logic [CW-1:0] idx);
    return pADDR_WIDTH'({idx, 2'b00});
  endfunction

  // Handshakes: a beat transfers in the cycle where valid and ready are both 1;
  // valid never depends on ready, and ss_tready is only high in WAIT_IN.
  assign accept     = (state == S_WAIT_IN) && ss_tvalid;
  assign last_beat  = (count == len - 1'b1);
  assign final_beat = (count + 1'b1 == len);

  // Newest sample sits at wr_ptr, so tap k pairs with data (wr_ptr - k) mod Tape_Num.
  always_comb begin
    if (k <= wr_ptr) mac_idx = {1'b0, wr_ptr} - {1'b0, k};
    else             mac_idx = {1'b0, wr_ptr} + (CW+1)'(Tape_Num) - {1'b0, k};
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n       = state;
    ss_tready     = 1'b0;
    sm_tvalid     = 1'b0;
    sm_tlast      = 1'b0;
    data_WE       = 4'h0;
    data_EN       = 1'b0;
    data_A        = '0;
    data_sel_zero = 1'b0;
    tap_EN        = 1'b0;
    tap_A         = '0;
    mac_clr       = 1'b0;
    ap_idle       = 1'b0;
    dbg_state     = state;
    case (state)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) state_n = S_CLR;
      end
      S_CLR: begin
        data_EN       = 1'b1;
        data_WE       = 4'hF;
        data_sel_zero = 1'b1;
        data_A        = to_byte(k);
        if (k == LAST_IDX) state_n = S_WAIT_IN;
      end
      S_WAIT_IN: begin
        ss_tready = 1'b1;
        data_A    = to_byte(wr_ptr);
        if (ss_tvalid) begin
          data_EN = 1'b1;
          data_WE = 4'hF;
          mac_clr = 1'b1;
          state_n = S_MAC;
        end
      end
      S_MAC: begin
        tap_EN  = 1'b1;
        data_EN = 1'b1;
        tap_A   = to_byte(k);
        data_A  = to_byte(mac_idx[CW-1:0]);
        if (k == LAST_IDX) state_n = S_DRAIN;
      end
      S_DRAIN: state_n = S_OUT;
      S_OUT: begin
        sm_tvalid = 1'b1;
        sm_tlast  = last_beat;
        if (sm_tready) state_n = final_beat ? S_DONE : S_WAIT_IN;
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      k       <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      len     <= '0;
      mac_en  <= 1'b0;
      ap_done <= 1'b0;
    end else begin
      // RAM read data arrives one cycle after the address, so accumulate one cycle late.
      mac_en <= (state == S_MAC);
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            len     <= (data_len == '0) ? pDATA_WIDTH'(1) : data_len;
            count   <= '0;
            wr_ptr  <= '0;
            k       <= '0;
            ap_done <= 1'b0;
          end
        end
        S_CLR: begin
          k <= (k == LAST_IDX) ? '0 : k + 1'b1;
          if (k == LAST_IDX) wr_ptr <= '0;
        end
        S_WAIT_IN: k <= '0;
        S_MAC:     k <= (k == LAST_IDX) ? '0 : k + 1'b1;
        S_DRAIN:   wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
        S_OUT: begin
          if (sm_tready) begin
            count <= count + 1'b1;
            if (final_beat) ap_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIR_SEQ_TLAST_CHK_EN
  logic err_q;
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst)                          err_q <= 1'b0;
    else if (state == S_IDLE && ap_start)  err_q <= 1'b0;
    else if (accept && (ss_tlast != last_beat)) err_q <= 1'b1;
  end
  assign err_tlast = err_q;
`else
  logic unused_tlast;
  assign unused_tlast = ss_tlast ^ accept;
  assign err_tlast    = 1'b0;
`endif

endmodule
